// File: rtl/grabor_pkg.sv
// rtl/grabor_pkg.sv - shared frame grabber constants and readout state encoding
package grabor_pkg;

    // Default SRAM address width of the grabber frame store
    localparam int DEF_ADDR_W = 19;

    // Frame header: columns LSB/MSB, rows LSB/MSB
    localparam int HDR_LEN = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PRESENT,
        STROBE,
        CSUM
    } rd_state_t;

endpackage

// File: rtl/frame_readout_if.sv
// rtl/frame_readout_if.sv - SRAM read port and MCU byte bus of the frame readout engine
interface frame_readout_if #(
    parameter int ADDR_W = grabor_pkg::DEF_ADDR_W
);
    logic [ADDR_W-1:0] sram_address;
    logic              sram_req;
    logic [7:0]        sram_q;
    logic [7:0]        pixelout;
    logic              outclk;
    logic              busy;
    logic              frame_end;

    // Readout engine side
    modport master (
        output sram_address, sram_req, pixelout, outclk, busy, frame_end,
        input  sram_q
    );

    // SRAM controller / MCU side
    modport slave (
        input  sram_address, sram_req, pixelout, outclk, busy, frame_end,
        output sram_q
    );

endinterface

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - 3-flop synchronizer with rising-edge pulse output
module edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise
);

    logic [2:0] r_sync;

    // Shift the asynchronous pin through three flops
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[1:0], i_async};
        end
    end

    // One-cycle pulse when the second stage sees a new high level
    assign o_rise = r_sync[1] & ~r_sync[2];

endmodule

// File: rtl/frame_readout.sv
// rtl/frame_readout.sv - SRAM to MCU byte-serial burst readout engine (option: READOUT_CHECKSUM_EN)
module frame_readout
    import grabor_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BURST_LEN = 2048,
    parameter int CLK_DIV   = 64,
    parameter int SRAM_LAT  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_xfr,
    input  logic              i_rewind,
    input  logic [ADDR_W-1:0] i_frame_bytes,
    frame_readout_if.master   bus
);

    localparam int CNT_W  = $clog2(BURST_LEN + 1);
    localparam int SLOT_W = $clog2(CLK_DIV);

    localparam logic [CNT_W-1:0]  CNT_MAX        = CNT_W'(BURST_LEN);
    localparam logic [SLOT_W-1:0] SLOT_LAT_LAST  = SLOT_W'(SRAM_LAT - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAT       = SLOT_W'(SRAM_LAT);
    localparam logic [SLOT_W-1:0] SLOT_HALF_LAST = SLOT_W'(CLK_DIV / 2 - 1);
    localparam logic [SLOT_W-1:0] SLOT_FE        = SLOT_W'(CLK_DIV - 2);
    localparam logic [SLOT_W-1:0] SLOT_LAST      = SLOT_W'(CLK_DIV - 1);

    rd_state_t         r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_fb;
    logic [CNT_W-1:0]  r_cnt;
    logic [SLOT_W-1:0] r_slot;
    logic [7:0]        r_pixel;
    logic              r_outclk;
    logic              r_busy;
    logic              r_sram_req;
    logic              r_frame_end;
    logic              r_rew_pend;
`ifdef READOUT_CHECKSUM_EN
    logic [7:0]        r_sum;
`endif

    logic              w_xfr_edge;
    logic              w_rew_edge;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_hit_end;

    edge_sync u_xfr_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_xfr),
        .o_rise  (w_xfr_edge)
    );

    edge_sync u_rew_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_rewind),
        .o_rise  (w_rew_edge)
    );

    assign w_ptr_nxt = r_ptr + ADDR_W'(1);
    assign w_cnt_nxt = r_cnt + CNT_W'(1);
    assign w_hit_end = (w_ptr_nxt == r_fb);

    // Burst sequencer: one CLK_DIV-cycle slot per byte, outputs all registered
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_fb        <= '0;
            r_cnt       <= '0;
            r_slot      <= '0;
            r_pixel     <= '0;
            r_outclk    <= 1'b0;
            r_busy      <= 1'b0;
            r_sram_req  <= 1'b0;
            r_frame_end <= 1'b0;
            r_rew_pend  <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            r_frame_end <= 1'b0;
            // A rewind during a burst must not disturb the running address
            if (r_state != IDLE && w_rew_edge) begin
                r_rew_pend <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    r_slot <= '0;
                    if (w_rew_edge || r_rew_pend) begin
                        r_ptr      <= '0;
                        r_rew_pend <= 1'b0;
                    end
                    if (w_xfr_edge) begin
                        r_fb       <= i_frame_bytes;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_sram_req <= 1'b1;
                        r_state    <= FETCH;
`ifdef READOUT_CHECKSUM_EN
                        r_sum      <= '0;
`endif
                    end
                end
                FETCH: begin
                    if (r_fb == '0) begin
                        // Empty frame: report the end immediately, no bytes
                        r_frame_end <= 1'b1;
                        r_ptr       <= '0;
                        r_busy      <= 1'b0;
                        r_sram_req  <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        if (r_slot == SLOT_LAT_LAST) begin
                            r_state <= PRESENT;
                        end
                        r_slot <= r_slot + SLOT_W'(1);
                    end
                end
                PRESENT: begin
                    if (r_slot == SLOT_LAT) begin
                        r_pixel <= bus.sram_q;
`ifdef READOUT_CHECKSUM_EN
                        r_sum   <= r_sum + bus.sram_q;
`endif
                    end
                    if (r_slot == SLOT_HALF_LAST) begin
                        r_outclk <= 1'b1;
                        r_state  <= STROBE;
                    end
                    r_slot <= r_slot + SLOT_W'(1);
                end
                STROBE: begin
                    // Registered so the pulse lands in the slot's last cycle
                    if (r_slot == SLOT_FE) begin
                        r_frame_end <= w_hit_end;
                    end
                    if (r_slot == SLOT_LAST) begin
                        r_outclk <= 1'b0;
                        r_slot   <= '0;
                        r_cnt    <= w_cnt_nxt;
                        r_ptr    <= w_hit_end ? '0 : w_ptr_nxt;
                        if (w_hit_end || w_cnt_nxt == CNT_MAX) begin
                            r_sram_req <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
                            r_state    <= CSUM;
`else
                            r_busy     <= 1'b0;
                            r_state    <= IDLE;
`endif
                        end else begin
                            r_state <= FETCH;
                        end
                    end else begin
                        r_slot <= r_slot + SLOT_W'(1);
                    end
                end
`ifdef READOUT_CHECKSUM_EN
                CSUM: begin
                    // Extra slot carrying the byte sum, same strobe shape
                    if (r_slot == SLOT_LAT) begin
                        r_pixel <= r_sum;
                    end
                    if (r_slot == SLOT_HALF_LAST) begin
                        r_outclk <= 1'b1;
                    end
                    if (r_slot == SLOT_LAST) begin
                        r_outclk <= 1'b0;
                        r_busy   <= 1'b0;
                        r_slot   <= '0;
                        r_state  <= IDLE;
                    end else begin
                        r_slot <= r_slot + SLOT_W'(1);
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sram_address = r_ptr;
    assign bus.sram_req     = r_sram_req;
    assign bus.pixelout     = r_pixel;
    assign bus.outclk       = r_outclk;
    assign bus.busy         = r_busy;
    assign bus.frame_end    = r_frame_end;

endmodule

// File: tb/tb_frame_readout.sv
// tb/tb_frame_readout.sv - scoreboard bench for frame_readout with randomized bursts
`timescale 1ns/1ps
module tb_frame_readout;
    import grabor_pkg::*;

    localparam int AW  = 19;
    localparam int BL  = 16;
    localparam int CD  = 8;
    localparam int LAT = 2;
`ifdef READOUT_CHECKSUM_EN
    localparam int CSUM_SLOTS = 1;
`else
    localparam int CSUM_SLOTS = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          xfr = 1'b0;
    logic          rewind = 1'b0;
    logic [AW-1:0] frame_bytes = '0;

    frame_readout_if #(.ADDR_W(AW)) bus ();

    frame_readout #(
        .ADDR_W    (AW),
        .BURST_LEN (BL),
        .CLK_DIV   (CD),
        .SRAM_LAT  (LAT)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_xfr         (xfr),
        .i_rewind      (rewind),
        .i_frame_bytes (frame_bytes),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // SRAM model: byte[i] = i mod 256, two-cycle read pipeline
    logic [7:0] sram_p1 = '0;
    always @(posedge clk) begin
        sram_p1    <= bus.sram_address[7:0];
        bus.sram_q <= sram_p1;
    end

    int n_chk  = 0;
    int n_fail = 0;
    int exp_q[$];
    int mptr   = 0;
    int fe_exp = 0;
    int fe_seen = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: pop the scoreboard on every outclk rise
    logic prev_oc = 1'b0;
    logic prev_fe = 1'b0;
    int   held    = 0;
    always @(negedge clk) begin
        if (bus.outclk && !prev_oc) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", int'(bus.pixelout), -1);
            end else begin
                chk("pixelout", int'(bus.pixelout), exp_q.pop_front());
            end
            held = int'(bus.pixelout);
        end
        if (!bus.outclk && prev_oc && !rst) begin
            chk("pixel_hold", int'(bus.pixelout), held);
        end
        if (bus.frame_end) begin
            fe_seen++;
            if (prev_fe) chk("frame_end_width", 2, 1);
        end
        prev_oc = bus.outclk;
        prev_fe = bus.frame_end;
    end

    // act: 0 none, 1 extra xfr pulse, 2 rewind pulse, 3 reset; act_t in cycles after the xfr pin edge
    task automatic run_burst(input int fb, input int act, input int act_t, input bit with_rew);
        int  n, sum, t, t_busy, t_clk, t_fall, exp_len;
        bit  aborted;
        frame_bytes = AW'(fb);
        if (with_rew) mptr = 0;
        n = 0;
        sum = 0;
        if (fb == 0) begin
            fe_exp++;
            mptr = 0;
        end else begin
            while (n < BL) begin
                exp_q.push_back(mptr % 256);
                sum += mptr % 256;
                n++;
                mptr = (mptr + 1) % (1 << AW);
                if (mptr == fb) begin
                    mptr = 0;
                    fe_exp++;
                    break;
                end
            end
            if (CSUM_SLOTS != 0) exp_q.push_back(sum % 256);
        end
        exp_len = (fb == 0) ? 1 : (n + CSUM_SLOTS) * CD;

        xfr = 1'b1;
        rewind = with_rew;
        t = 0; t_busy = -1; t_clk = -1; t_fall = -1; aborted = 1'b0;
        while (t < 400 && t_fall < 0 && !aborted) begin
            @(posedge clk); #1;
            t++;
            if (t_busy < 0 && bus.busy) t_busy = t;
            if (t_clk < 0 && bus.outclk) t_clk = t;
            if (t_busy >= 0 && !bus.busy) t_fall = t;
            if (t == 4) begin xfr = 1'b0; rewind = 1'b0; end
            if (act == 1 && t == act_t) xfr = 1'b1;
            if (act == 2 && t == act_t) begin rewind = 1'b1; mptr = 0; end
            if ((act == 1 || act == 2) && t == act_t + 4) begin xfr = 1'b0; rewind = 1'b0; end
            if (act == 3 && t == act_t) begin
                rst = 1'b1;
                @(posedge clk); #1;
                chk("rst_outclk", int'(bus.outclk), 0);
                chk("rst_busy", int'(bus.busy), 0);
                chk("rst_address", int'(bus.sram_address), 0);
                rst = 1'b0;
                exp_q.delete();
                mptr = 0;
                aborted = 1'b1;
            end
        end
        if (!aborted) begin
            chk("busy_fall_timeout", int'(t_fall >= 0), 1);
            chk("start_latency", t_busy, 3);
            chk("first_outclk", t_clk, (n > 0) ? 3 + CD / 2 : -1);
            chk("busy_length", t_fall - t_busy, exp_len);
        end
        repeat (6) @(posedge clk);
        #1;
        chk("bytes_left", exp_q.size(), 0);
        chk("frame_end_count", fe_seen, fe_exp);
    endtask

    task automatic idle_rewind();
        rewind = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rewind = 1'b0;
        mptr = 0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int fb;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pixelout", int'(bus.pixelout), 0);
        chk("reset_outclk", int'(bus.outclk), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_frame_end", int'(bus.frame_end), 0);
        chk("reset_sram_req", int'(bus.sram_req), 0);
        chk("reset_address", int'(bus.sram_address), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run_burst(40, 0, 0, 1'b0);                 // 0..15
        run_burst(40, 0, 0, 1'b0);                 // 16..31
        run_burst(40, 0, 0, 1'b0);                 // 32..39, frame_end
        run_burst(40, 1, 30, 1'b0);                // extra xfr ignored, 0..15
        run_burst(40, 2, 3 + CD / 2 + 5 * CD, 1'b0); // rewind at byte 5
        run_burst(40, 0, 0, 1'b0);                 // restarts at 0
        run_burst(40, 3, 3 + CD / 2 + 7 * CD - 3, 1'b0); // reset before byte 7
        run_burst(40, 0, 0, 1'b0);                 // 0..15 after reset
        run_burst(0, 0, 0, 1'b0);                  // empty frame
        run_burst(40, 0, 0, 1'b0);
        run_burst(40, 0, 0, 1'b1);                 // rewind with xfr: starts at 0

        fb = 40;
        for (int i = 0; i < 12; i++) begin
            if (mptr == 0) fb = HDR_LEN + $urandom_range(0, 40);
            if ($urandom_range(0, 3) == 0) idle_rewind();
            run_burst(fb, 0, 0, $urandom_range(0, 4) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_readout.md
# frame_readout

Byte-serial readout engine between the SRAM controller and the MCU DMA port. On each MCU transfer request it reads one burst of the captured frame (header bytes plus pixels) from SRAM and presents it on an 8-bit bus, marking each byte with an output clock strobe. It replaces the ad-hoc pulse counter in the grabber top level and owns the SRAM address while a burst is in progress.

## Interface
Parameters:
- ADDR_W, 19: SRAM address width.
- BURST_LEN, 2048: bytes per transfer request.
- CLK_DIV, 64: clk cycles per output byte slot; even, ≥ 2*SRAM_LAT+4.
- SRAM_LAT, 2: clk cycles from address change to valid sram_q.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- xfr  in  1  MCU transfer request; asynchronous; a rising edge starts a burst.
- rewind  in  1  asynchronous; a rising edge resets the read pointer to 0.
- frame_bytes  in  ADDR_W  total valid bytes in SRAM; sampled at burst start.
- sram_address  out  ADDR_W  read address to the SRAM controller.
- sram_q  in  8  read data from the SRAM controller.
- sram_req  out  1  high while the block owns the SRAM address.
- pixelout  out  8  byte bus to the MCU.
- outclk  out  1  byte strobe; the MCU samples pixelout on its rising edge.
- busy  out  1  burst in progress.
- frame_end  out  1  one-cycle pulse when the read pointer reaches frame_bytes.

## Operation
- xfr and rewind each pass through a 3-flop synchronizer with rising-edge detect, so the edge is seen 2 cycles after the pin changes.
- States:
  - IDLE: waits for an xfr edge. On the edge: latch frame_bytes, clear the burst counter, enter FETCH.
  - FETCH: drive sram_address = read pointer; wait SRAM_LAT cycles.
  - PRESENT: load pixelout <= sram_q. Hold outclk low until slot cycle CLK_DIV/2.
  - STROBE: drive outclk high for the rest of the slot, then:
    - increment the pointer and burst counter;
    - if the pointer equals the latched frame_bytes, or the counter equals BURST_LEN, end the burst;
    - otherwise go to FETCH.
- Burst end: go to CSUM when that feature is compiled in, else IDLE.
- When the pointer reaches frame_bytes:
  - pulse frame_end;
  - wrap the pointer to 0.
- The pointer persists across bursts, so successive xfr edges walk through the frame.
- Pointer arithmetic is modulo 2^ADDR_W. The burst counter is clog2(BURST_LEN+1) bits.
- Boundary cases:
  - xfr edge while busy: ignored.
  - rewind edge while idle: pointer <= 0 on the next cycle.
  - rewind edge while busy: held pending and applied on the return to IDLE.
  - rewind and xfr edges in the same cycle while idle: rewind applies first; the burst starts at address 0.
  - frame_bytes == 0 at start: no strobes; one frame_end pulse; return to IDLE within 2 cycles; busy stays high for 1 cycle.
  - rst mid-burst: the next edge gives outclk=0, busy=0, pointer 0, and the pending rewind is cleared.

## Timing
- Reset values: pixelout 0, outclk 0, busy 0, frame_end 0, sram_req 0, sram_address 0.
- Latency: an xfr pin edge produces the first sram_address 3 cycles later.
- Slot timing: the first outclk rise comes 3 + CLK_DIV/2 cycles after the pin edge. Each byte occupies exactly CLK_DIV cycles.
- Output bus timing:
  - pixelout changes only at slot cycle SRAM_LAT, while outclk is low;
  - pixelout is stable for at least CLK_DIV/2−SRAM_LAT cycles before the outclk rise and CLK_DIV/2 cycles after it.
- Duty cycle: outclk is high for CLK_DIV/2 cycles per slot.
- busy and sram_req rise together with the first FETCH cycle. They fall on the cycle after the last slot (after CSUM when it is enabled).
- frame_end is asserted in the last cycle of the final byte's slot.

## Configuration
- READOUT_CHECKSUM_EN defined:
  - an 8-bit running sum (mod 256) of the burst's bytes is cleared at burst start;
  - after the last data byte, one extra CLK_DIV slot (CSUM state) presents the sum on pixelout with a normal outclk strobe;
  - sram_req is low during CSUM.
- Undefined: no CSUM state, and the burst is exactly the data bytes.

## Structure
- Shared package grabor_pkg holds:
  - ADDR_W default;
  - the header length constant (4 bytes: columns LSB/MSB, rows LSB/MSB);
  - the readout state enum (IDLE, FETCH, PRESENT, STROBE, CSUM).
- One sub-module, edge_sync: 3-flop synchronizer with rising-edge output. It is instantiated twice, for xfr and rewind.

## Test plan
- Bench setup: SRAM model with SRAM_LAT=2, contents byte[i] = i mod 256. Parameters CLK_DIV=8, BURST_LEN=16.
- frame_bytes=40, one xfr: 16 outclk rises with pixelout 0..15; busy falls after 128+ cycles; no frame_end.
- Three xfr edges: bytes 16..31, then 32..39 with a frame_end pulse after byte 39; the next burst starts at 0.
- xfr pulsed again mid-burst: ignored; exactly 16 strobes total.
- rewind asserted mid-burst at byte 5: burst completes with bytes 0..15; the next burst starts at 0, not 16.
- rst at byte 7: outclk=0 and busy=0 on the next edge; a subsequent xfr yields bytes 0..15.
- READOUT_CHECKSUM_EN with bytes 0..15: a 17th strobe carries 0x78 (sum 120). frame_bytes=0 gives no strobes and one frame_end pulse.
